// File: rtl/stopwatch_timer.sv
// BCD stopwatch MM:SS.cc with run/stop, clear, preset load, up/down mode and lap freeze.
// Digits are packed {m1,m0,s1,s0,c1,c0}; the count always advances beneath a frozen lap display.
module stopwatch_timer #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_MIN = 59
) (
    input  logic        clk_50m,
    input  logic        rst,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        mode,
    input  logic        lap,
    output logic [23:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        wrap,
    output logic        done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [3:0]  MAX_M1    = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_M0    = 4'(MAX_MIN % 10);
    localparam logic [23:0] MAX_COUNT = {MAX_M1, MAX_M0, 16'h5999};

    logic [23:0]   cnt_q, cnt_d;
    logic [23:0]   lap_q, lap_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          run_q, run_d;
    logic          lap_act_q, lap_act_d;
    logic          wrap_q, wrap_d;
    logic          done_q, done_d;
    logic          tick;

    function automatic logic [23:0] count_inc(input logic [23:0] v);
        logic [3:0] m1, m0, s1, s0, c1, c0;
        {m1, m0, s1, s0, c1, c0} = v;
        if (c0 != 4'd9) c0 = c0 + 4'd1;
        else begin
            c0 = 4'd0;
            if (c1 != 4'd9) c1 = c1 + 4'd1;
            else begin
                c1 = 4'd0;
                if (s0 != 4'd9) s0 = s0 + 4'd1;
                else begin
                    s0 = 4'd0;
                    if (s1 != 4'd5) s1 = s1 + 4'd1;
                    else begin
                        s1 = 4'd0;
                        if (m1 == MAX_M1 && m0 == MAX_M0) begin
                            m1 = 4'd0;
                            m0 = 4'd0;
                        end else if (m0 != 4'd9) m0 = m0 + 4'd1;
                        else begin
                            m0 = 4'd0;
                            m1 = m1 + 4'd1;
                        end
                    end
                end
            end
        end
        return {m1, m0, s1, s0, c1, c0};
    endfunction

    function automatic logic [23:0] count_dec(input logic [23:0] v);
        logic [3:0] m1, m0, s1, s0, c1, c0;
        {m1, m0, s1, s0, c1, c0} = v;
        if (c0 != 4'd0) c0 = c0 - 4'd1;
        else begin
            c0 = 4'd9;
            if (c1 != 4'd0) c1 = c1 - 4'd1;
            else begin
                c1 = 4'd9;
                if (s0 != 4'd0) s0 = s0 - 4'd1;
                else begin
                    s0 = 4'd9;
                    if (s1 != 4'd0) s1 = s1 - 4'd1;
                    else begin
                        s1 = 4'd5;
                        if (m1 == 4'd0 && m0 == 4'd0) begin
                            m1 = MAX_M1;
                            m0 = MAX_M0;
                        end else if (m0 != 4'd0) m0 = m0 - 4'd1;
                        else begin
                            m0 = 4'd9;
                            m1 = m1 - 4'd1;
                        end
                    end
                end
            end
        end
        return {m1, m0, s1, s0, c1, c0};
    endfunction

    // Each out-of-range field clamps to its own maximum; minutes clamp after digit clamping.
    function automatic logic [23:0] sat_load(input logic [23:0] v);
        logic [3:0] m1, m0, s1, s0, c1, c0;
        logic [7:0] mv;
        m1 = (v[23:20] > 4'd9) ? 4'd9 : v[23:20];
        m0 = (v[19:16] > 4'd9) ? 4'd9 : v[19:16];
        s1 = (v[15:12] > 4'd5) ? 4'd5 : v[15:12];
        s0 = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
        c1 = (v[7:4]   > 4'd9) ? 4'd9 : v[7:4];
        c0 = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
        mv = {4'd0, m1} * 8'd10 + {4'd0, m0};
        if (mv > 8'(MAX_MIN)) begin
            m1 = MAX_M1;
            m0 = MAX_M0;
        end
        return {m1, m0, s1, s0, c1, c0};
    endfunction

    assign tick = run_q && (pre_q == PW'(DIV - 1));

    always_comb begin
        cnt_d     = cnt_q;
        lap_d     = lap_q;
        pre_d     = pre_q;
        run_d     = run_q;
        lap_act_d = lap_act_q;
        wrap_d    = 1'b0;
        done_d    = 1'b0;
        if (clear) begin
            cnt_d     = 24'h0;
            pre_d     = '0;
            run_d     = 1'b0;
            lap_act_d = 1'b0;
        end else if (load) begin
            cnt_d = sat_load(load_val);
            pre_d = '0;
        end else begin
            if (run_q) pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick) begin
                if (!mode) begin
                    cnt_d  = count_inc(cnt_q);
                    wrap_d = (cnt_q == MAX_COUNT);
                end else if (cnt_q == 24'h0) begin
                    // Down-counting from zero has nothing left to do; just stop.
                    run_d = 1'b0;
                end else begin
                    cnt_d = count_dec(cnt_q);
                    if (cnt_q == 24'h000001) begin
                        run_d  = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            if (start_stop && !(mode && cnt_q == 24'h0)) run_d = !run_q;
            if (lap) begin
                if (run_q) begin
                    lap_d     = cnt_q;
                    lap_act_d = 1'b1;
                end else begin
                    lap_act_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            cnt_q     <= 24'h0;
            lap_q     <= 24'h0;
            pre_q     <= '0;
            run_q     <= 1'b0;
            lap_act_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lap_q     <= lap_d;
            pre_q     <= pre_d;
            run_q     <= run_d;
            lap_act_q <= lap_act_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign digits     = lap_act_q ? lap_q : cnt_q;
    assign running    = run_q;
    assign lap_active = lap_act_q;
    assign wrap       = wrap_q;
    assign done       = done_q;

endmodule
